uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with a receive buffer and a ready/valid output.
//            Defining UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO.
//            Without that macro, a single holding register is used instead.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_param_check
        $error("uart_rx_fifo: illegal CLKS_PER_BIT or FIFO_DEPTH");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic               r_rx_meta;
    logic               r_rx_sync;
    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic [c_cnt_w-1:0] w_clk_cnt_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               w_stop_ok;
    logic               w_stop_bad;
    logic               r_push;
    logic [7:0]         r_push_data;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_pop;
    logic               w_wr;

    // Synchronizer resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_push      <= w_stop_ok;
            r_push_data <= r_shift;
            r_frame_err <= w_stop_bad;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_stop_ok      = 1'b0;
        w_stop_bad     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_clk_cnt_next = '0;
                if (!r_rx_sync) begin
                    w_state_next   = S_START;
                    w_bit_idx_next = '0;
                end
            end
            S_START: begin
                if (r_clk_cnt == c_half_last) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + c_cnt_w'(1);
                end
            end
            S_DATA: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + c_cnt_w'(1);
                end
            end
            S_STOP: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_clk_cnt_next = '0;
                    if (r_rx_sync) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + c_cnt_w'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_sync) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int                 c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int                 c_occ_w    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_occ_w-1:0] c_full_occ = c_occ_w'(FIFO_DEPTH);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occ;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (r_occ == c_full_occ);
    assign w_empty = (r_occ == '0);
    assign w_pop   = !w_empty && ready_i;
    // A pop on the same edge frees the slot the write pointer is aiming at
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_occ <= r_occ + c_occ_w'(1);
                2'b01:   r_occ <= r_occ - c_occ_w'(1);
                default: r_occ <= r_occ;
            endcase
            r_overrun <= r_push && !w_wr;
        end
    end

    assign valid_o = !w_empty;
    assign data_o  = r_mem[r_rd_ptr];
`else
    logic [7:0] r_hold_data;
    logic       r_hold_valid;

    assign w_pop = r_hold_valid && ready_i;
    assign w_wr  = r_push && (!r_hold_valid || w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_hold_data  <= r_push_data;
                r_hold_valid <= 1'b1;
            end else if (w_pop) begin
                r_hold_valid <= 1'b0;
            end
            r_overrun <= r_push && !w_wr;
        end
    end

    assign valid_o = r_hold_valid;
    assign data_o  = r_hold_data;
`endif

    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int         checks = 0;
    int         failures = 0;

    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         valid_cycles = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'h00;
    logic       rand_ready = 1'b0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    // One clock: observe on the falling edge, then drive just after the rising edge
    task automatic tick();
        @(negedge clk);
        if (resetn) begin
            if (stall_prev) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== held) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b data=%02h required valid=1 data=%02h",
                             valid_o, data_o, held);
                end
            end
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (valid_o) valid_cycles++;
            if (frame_err_o) fe_cnt++;
            if (overrun_o) ov_cnt++;
            stall_prev = valid_o && !ready_i;
            held = data_o;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        got_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL %s valid=%b data=%02h fe=%b ov=%b required all zero",
                     tag, valid_o, data_o, frame_err_o, overrun_o);
        end
    endtask

    task automatic check_one_byte(input string tag, input logic [7:0] exp);
        logic [7:0] g;
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL %s_count got=%0d required=1", tag, got_q.size());
        end
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (g !== exp) begin
            failures++;
            $display("FAIL %s_data got=%02h required=%02h", tag, g, exp);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rx = 1'b1;
        ready_i = 1'b0;
        idle(3);
        check_outputs_zero("reset_state");
        resetn = 1'b1;
        idle(3);
        check_outputs_zero("post_reset_idle");
    endtask

    task automatic test_single();
        clear_mon();
        ready_i = 1'b1;
        send_byte(8'h55, 1'b1);
        idle(3 * CPB);
        check_one_byte("single", 8'h55);
        checks++;
        if (valid_cycles != 1) begin
            failures++;
            $display("FAIL single_valid_cycles got=%0d required=1", valid_cycles);
        end
        checks++;
        if (fe_cnt != 0 || ov_cnt != 0) begin
            failures++;
            $display("FAIL single_err_pulses fe=%0d ov=%0d required 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        ready_i = 1'b1;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        idle(4 * CPB);
        checks++;
        if (valid_cycles != 0 || fe_cnt != 0) begin
            failures++;
            $display("FAIL glitch_output valid_cycles=%0d fe=%0d required 0 0", valid_cycles, fe_cnt);
        end
        send_byte(8'hC7, 1'b1);
        idle(3 * CPB);
        check_one_byte("after_glitch", 8'hC7);
    endtask

    task automatic test_frame_err();
        clear_mon();
        ready_i = 1'b1;
        send_byte(8'hA3, 1'b0);
        idle(2 * CPB);
        checks++;
        if (fe_cnt != 1) begin
            failures++;
            $display("FAIL frame_err_pulses got=%0d required=1", fe_cnt);
        end
        checks++;
        if (valid_cycles != 0) begin
            failures++;
            $display("FAIL frame_err_valid got=%0d required=0", valid_cycles);
        end
        send_byte(8'h3C, 1'b1);
        idle(3 * CPB);
        check_one_byte("after_frame_err", 8'h3C);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        ready_i = 1'b1;
        send_byte(8'h5A, 1'b1);
        send_byte(8'hF0, 1'b1);
        idle(3 * CPB);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'h5A || got_q[1] !== 8'hF0) begin
            failures++;
            $display("FAIL back_to_back got_count=%0d required 2 bytes 5a f0", got_q.size());
        end
    endtask

    task automatic test_overrun();
        logic [7:0] stim[$];
        logic [7:0] model_q[$];
        logic [7:0] g;
        int exp_ov;
        clear_mon();
`ifdef UART_RX_FIFO_EN
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
        stim = '{8'h11, 8'h22};
`endif
        exp_ov = 0;
        ready_i = 1'b0;
        foreach (stim[k]) begin
            send_byte(stim[k], 1'b1);
            idle(2 * CPB);
            if (model_q.size() < CAP) model_q.push_back(stim[k]);
            else exp_ov++;
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== model_q[0]) begin
            failures++;
            $display("FAIL overrun_head valid=%b data=%02h required valid=1 data=%02h",
                     valid_o, data_o, model_q[0]);
        end
        checks++;
        if (ov_cnt != exp_ov) begin
            failures++;
            $display("FAIL overrun_pulses got=%0d required=%0d", ov_cnt, exp_ov);
        end
        ready_i = 1'b1;
        idle(CAP + 4);
        checks++;
        if (got_q.size() != model_q.size()) begin
            failures++;
            $display("FAIL overrun_drain_count got=%0d required=%0d", got_q.size(), model_q.size());
        end
        foreach (model_q[k]) begin
            g = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (g !== model_q[k]) begin
                failures++;
                $display("FAIL overrun_drain_%0d got=%02h required=%02h", k, g, model_q[k]);
            end
        end
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL overrun_empty valid=%b required=0", valid_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       stop_bit;
        int         exp_fe;
        clear_mon();
        exp_fe = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            send_byte(b, stop_bit);
            idle(2 * CPB + $urandom_range(0, 2 * CPB));
            if (stop_bit) exp_q.push_back(b);
            else exp_fe++;
        end
        rand_ready = 1'b0;
        ready_i = 1'b1;
        idle(10);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (b !== exp_q[k]) begin
                failures++;
                $display("FAIL random_byte_%0d got=%02h required=%02h", k, b, exp_q[k]);
            end
        end
        checks++;
        if (fe_cnt != exp_fe || ov_cnt != 0) begin
            failures++;
            $display("FAIL random_pulses fe=%0d ov=%0d required fe=%0d ov=0", fe_cnt, ov_cnt, exp_fe);
        end
    endtask

    task automatic test_reset_mid_byte();
        clear_mon();
        ready_i = 1'b1;
        rx = 1'b0;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (3 * CPB + 2) tick();
        resetn = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        idle(3);
        check_outputs_zero("reset_held");
        resetn = 1'b1;
        idle(2);
        send_byte(8'h81, 1'b1);
        idle(3 * CPB);
        check_one_byte("after_reset", 8'h81);
        checks++;
        if (fe_cnt != 0 || ov_cnt != 0) begin
            failures++;
            $display("FAIL after_reset_pulses fe=%0d ov=%0d required 0 0", fe_cnt, ov_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_overrun();
        test_random();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
